axi_cmd_master: RTL and testbench

AXI4 initiator that turns simple single-burst commands into one AXI4 INCR read or write burst at a time. It streams write data in from a local valid/ready port and streams read data out to one. It reports a one-cycle completion status per command. The block is the counterpart of the team's `axi_ram` responder and drives it, or any AXI4 slave, from control logic such as boot loaders and test engines.

---
 rtl/axi_master_pkg.sv | 24 ++
 rtl/axi_cmd_master.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_cmd_master.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_pkg.sv
// Shared types and fixed AXI field values for the single-burst AXI4 command master.
package axi_master_pkg;

  // Controller states. Exactly one command is in flight at a time.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;

endpackage

// File: rtl/axi_cmd_master.sv
// Turns one local command into one AXI4 INCR burst, streaming write data in
// and read data out, and reports a one-cycle completion status per command.
//
// Handshakes: every valid/ready pair transfers on a rising clock edge where
// both are high; a valid, once raised, holds its payload until that edge.
module axi_cmd_master
  import axi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  sts_valid,
  output logic                  sts_write,
  output logic [1:0]            sts_resp,
  output logic                  busy,
  output logic [2:0]            dbg_state,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int SIZE_BITS = $clog2(STRB_WIDTH);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [1:0]            resp_q;
  logic                  sts_valid_q;
  logic                  sts_write_q;
  logic                  cmd_fire, w_fire, b_fire, r_fire, cnt_zero;

  // Only one command at a time, so IDLE is the only state that can take one.
  assign cmd_ready = (state == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cnt_zero  = (cnt_q == 8'd0);
  assign w_fire    = (state == ST_WR_DATA) && wr_valid && m_axi_wready;
  assign b_fire    = (state == ST_WR_RESP) && m_axi_bvalid;
  assign r_fire    = (state == ST_RD_DATA) && m_axi_rvalid && rd_ready;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign sts_valid = sts_valid_q;
  assign sts_write = sts_write_q;
  assign sts_resp  = resp_q;

  // Address-channel fields come straight from registers, so they cannot move
  // while a valid is waiting for its ready.
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE_BITS);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE_BITS);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = PROT_DEFAULT;

  // Beat payloads pass straight through; last-beat flags come from our own
  // counter, never from the responder.
  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign m_axi_wlast = cnt_zero;
  assign rd_data     = m_axi_rdata;
  assign rd_last     = cnt_zero;

  // Response IDs are not checked: only one burst is ever outstanding.
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the per-state channel valids/readies.
  always_comb begin
    state_next    = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) state_next = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
      end
      ST_WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        if (w_fire && cnt_zero) state_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = ST_IDLE;
      end
      ST_RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        if (r_fire && cnt_zero) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch and beat counter; the address is aligned down to the beat size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q <= {cmd_addr[ADDR_WIDTH-1:SIZE_BITS], {SIZE_BITS{1'b0}}};
        len_q  <= cmd_len;
        cnt_q  <= cmd_len;
      end else if (w_fire || r_fire) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // Response accumulation and the one-cycle completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q      <= RESP_OKAY;
      sts_valid_q <= 1'b0;
      sts_write_q <= 1'b0;
    end else begin
      sts_valid_q <= 1'b0;
      if (cmd_fire) resp_q <= RESP_OKAY;
      if (b_fire) begin
        resp_q      <= m_axi_bresp;
        sts_valid_q <= 1'b1;
        sts_write_q <= 1'b1;
      end
      if (r_fire) begin
        // The first bad beat wins; a framing mismatch only counts if no
        // responder error has been seen yet.
        if (resp_q == RESP_OKAY) begin
          if (m_axi_rresp != RESP_OKAY)    resp_q <= m_axi_rresp;
          else if (m_axi_rlast != cnt_zero) resp_q <= RESP_SLVERR;
        end
        if (cnt_zero) begin
          sts_valid_q <= 1'b1;
          sts_write_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_cmd_master.sv
// Bench for axi_cmd_master: a memory-backed AXI4 responder with scripted
// error injection, a table of directed commands, hand-written reset and
// backpressure sequences, and randomized commands against a shadow memory.
module tb_axi_cmd_master;
  import axi_master_pkg::*;

  localparam int BUDGET = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // DUT connections
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        sts_valid, sts_write;
  logic [1:0]  sts_resp;
  logic        busy;
  logic [2:0]  dbg_state;
  logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .AXI_ID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .sts_valid(sts_valid), .sts_write(sts_write), .sts_resp(sts_resp),
    .busy(busy), .dbg_state(dbg_state),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // ---------------- responder model ----------------
  bit          rand_slave = 1'b0;
  logic [1:0]  inj_bresp = 2'b00;
  int          inj_rerr_beat = -1;
  logic [1:0]  inj_rerr_val = 2'b00;
  int          inj_rlast_early = -1;

  logic [31:0] mem [0:16383];
  logic        aw_rdy, w_rdy, b_gate, ar_rdy, r_gate;
  logic        w_act, b_pend, r_act;
  logic [13:0] w_idx, r_idx;
  int          r_beat, r_len;

  assign m_axi_awready = aw_rdy;
  assign m_axi_wready  = w_act && w_rdy;
  assign m_axi_bvalid  = b_pend && b_gate;
  assign m_axi_bresp   = inj_bresp;
  assign m_axi_bid     = 8'h00;
  assign m_axi_arready = ar_rdy;
  assign m_axi_rvalid  = r_act && r_gate;
  assign m_axi_rdata   = mem[r_idx];
  assign m_axi_rresp   = (r_beat == inj_rerr_beat) ? inj_rerr_val : 2'b00;
  assign m_axi_rlast   = (inj_rlast_early >= 0) ? (r_beat == inj_rlast_early) : (r_beat == r_len);
  assign m_axi_rid     = 8'h00;

  // Responder: word memory, one burst per channel, optional random stalls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_rdy <= 1'b0; w_rdy <= 1'b0; b_gate <= 1'b0; ar_rdy <= 1'b0; r_gate <= 1'b0;
      w_act <= 1'b0; b_pend <= 1'b0; r_act <= 1'b0;
      w_idx <= '0; r_idx <= '0; r_beat <= 0; r_len <= 0;
      for (int i = 0; i < 16384; i++) mem[i] <= '0;
    end else begin
      aw_rdy <= rand_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
      w_rdy  <= rand_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
      b_gate <= rand_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
      ar_rdy <= rand_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
      r_gate <= rand_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (m_axi_awvalid && m_axi_awready) begin
        w_idx <= m_axi_awaddr[15:2];
        w_act <= 1'b1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        mem[w_idx] <= merge(mem[w_idx], m_axi_wdata, m_axi_wstrb);
        w_idx <= w_idx + 14'd1;
        if (m_axi_wlast) begin
          w_act  <= 1'b0;
          b_pend <= 1'b1;
        end
      end
      if (m_axi_bvalid && m_axi_bready) b_pend <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        r_idx  <= m_axi_araddr[15:2];
        r_len  <= int'(m_axi_arlen);
        r_beat <= 0;
        r_act  <= 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        r_idx  <= r_idx + 14'd1;
        r_beat <= r_beat + 1;
        if (r_beat == r_len) r_act <= 1'b0;
      end
    end
  end

  // ---------------- address-channel monitor ----------------
  logic        aw_pend = 1'b0, ar_pend = 1'b0;
  logic [15:0] aw_hold_addr, ar_hold_addr;
  logic [7:0]  aw_hold_len, ar_hold_len;
  int          stab_err = 0;
  logic [15:0] cap_addr;
  logic [7:0]  cap_len;
  logic [2:0]  cap_size;
  logic [1:0]  cap_burst;
  logic [15:0] cap_fixed;

  // Captures address beats and flags any valid/payload change before ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== aw_hold_addr || m_axi_awlen !== aw_hold_len))
        stab_err <= stab_err + 1;
      if (ar_pend && (!m_axi_arvalid || m_axi_araddr !== ar_hold_addr || m_axi_arlen !== ar_hold_len))
        stab_err <= stab_err + 1;
      aw_pend <= m_axi_awvalid && !m_axi_awready;
      ar_pend <= m_axi_arvalid && !m_axi_arready;
      aw_hold_addr <= m_axi_awaddr; aw_hold_len <= m_axi_awlen;
      ar_hold_addr <= m_axi_araddr; ar_hold_len <= m_axi_arlen;
      if (m_axi_awvalid && m_axi_awready) begin
        cap_addr <= m_axi_awaddr; cap_len <= m_axi_awlen; cap_size <= m_axi_awsize;
        cap_burst <= m_axi_awburst;
        cap_fixed <= {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awid};
      end
      if (m_axi_arvalid && m_axi_arready) begin
        cap_addr <= m_axi_araddr; cap_len <= m_axi_arlen; cap_size <= m_axi_arsize;
        cap_burst <= m_axi_arburst;
        cap_fixed <= {m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arid};
      end
    end else begin
      aw_pend <= 1'b0;
      ar_pend <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] shadow [int];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_strb [$];

  function automatic logic [31:0] shadow_rd(input int idx);
    return shadow.exists(idx) ? shadow[idx] : 32'h0;
  endfunction

  task automatic fill_wq(input int n, input bit pattern, input bit rand_strb);
    wq_data.delete();
    wq_strb.delete();
    for (int b = 0; b < n; b++) begin
      wq_data.push_back(pattern ? 32'h11111111 * (b + 1) : $urandom);
      wq_strb.push_back(rand_strb ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  // ---------------- drivers ----------------
  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic accept_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                            input string tag);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = cmd_ready;
      if (!ok) begin @(posedge clk); #1; end
    end
    chk({tag, "_accept"}, ok, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // mode 0: streams always ready; 1: toggle 1,0,1,0; 2: random.
  task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                         input int mode, input logic [1:0] exp_resp,
                         input logic [15:0] exp_aaddr, input string tag);
    int bo, bi, errs, fin_cyc, sts_cyc;
    bit ph, v, sts_w, rdy_s;
    logic [1:0] sts_r;
    bo = 0; bi = 0; errs = 0; fin_cyc = -1; sts_cyc = -1; ph = 1'b1;
    sts_w = 1'b0; rdy_s = 1'b0; sts_r = 2'b00;
    accept_cmd(wr, addr, len, tag);
    for (int cyc = 0; cyc < BUDGET && sts_cyc < 0; cyc++) begin
      case (mode)
        1:       v = ph;
        2:       v = 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      ph = !ph;
      if (wr) begin
        wr_valid = v && (bo <= int'(len));
        if (bo <= int'(len)) begin wr_data = wq_data[bo]; wr_strb = wq_strb[bo]; end
      end else begin
        rd_ready = v;
      end
      @(negedge clk);
      if (cyc == 0) chk({tag, "_avalid_n1"}, wr ? m_axi_awvalid : m_axi_arvalid, 1'b1);
      if (m_axi_wvalid && !wr_valid) errs++;
      if (wr_ready && !m_axi_wready) errs++;
      if (m_axi_rready && !rd_ready) errs++;
      if (rd_valid && !m_axi_rvalid) errs++;
      if (wr_valid && wr_ready) begin
        if (m_axi_wdata !== wr_data || m_axi_wstrb !== wr_strb || m_axi_wlast !== (bo == int'(len)))
          errs++;
        bo++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        fin_cyc = cycle_cnt;
        if (cmd_ready !== 1'b0) errs++;
      end
      if (rd_valid && rd_ready) begin
        if (bi > int'(len)) errs++;
        else if (rd_data !== shadow_rd(int'(addr >> 2) + bi) || rd_last !== (bi == int'(len))) errs++;
        if (bi == int'(len)) fin_cyc = cycle_cnt;
        bi++;
      end
      if (sts_valid) begin
        sts_cyc = cycle_cnt; sts_w = sts_write; sts_r = sts_resp; rdy_s = cmd_ready;
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk({tag, "_sts_seen"}, sts_cyc >= 0, 1'b1);
    chk({tag, "_sts_timing"}, sts_cyc - fin_cyc, 1);
    chk({tag, "_sts_write"}, sts_w, wr);
    chk({tag, "_sts_resp"}, sts_r, exp_resp);
    chk({tag, "_ready_at_sts"}, rdy_s, 1'b1);
    chk({tag, "_beats"}, wr ? bo : bi, int'(len) + 1);
    chk({tag, "_stream_errs"}, errs, 0);
    chk({tag, "_aaddr"}, cap_addr, exp_aaddr);
    chk({tag, "_alen"}, cap_len, len);
    chk({tag, "_asize"}, cap_size, 3'd2);
    chk({tag, "_aburst"}, cap_burst, 2'b01);
    chk({tag, "_afixed"}, cap_fixed, {1'b0, 4'b0011, 3'b000, 8'h00});
    @(negedge clk);
    chk({tag, "_sts_one_cycle"}, sts_valid, 1'b0);
    if (wr)
      for (int b = 0; b <= int'(len); b++)
        shadow[int'(addr >> 2) + b] = merge(shadow_rd(int'(addr >> 2) + b), wq_data[b], wq_strb[b]);
    @(posedge clk); #1;
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [1:0]  bresp;
    int          rerr_beat;
    logic [1:0]  rerr_val;
    int          rlast_early;
    logic [1:0]  exp_resp;
    logic [15:0] exp_aaddr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sts_seen;
    bit hs;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;

    vecs[0] = '{1'b1, 16'h0100, 8'd3, RESP_OKAY,   -1, RESP_OKAY,   -1, RESP_OKAY,   16'h0100};
    vecs[1] = '{1'b0, 16'h0100, 8'd3, RESP_OKAY,   -1, RESP_OKAY,   -1, RESP_OKAY,   16'h0100};
    vecs[2] = '{1'b1, 16'h0103, 8'd1, RESP_OKAY,   -1, RESP_OKAY,   -1, RESP_OKAY,   16'h0100};
    vecs[3] = '{1'b1, 16'h0108, 8'd0, RESP_OKAY,   -1, RESP_OKAY,   -1, RESP_OKAY,   16'h0108};
    vecs[4] = '{1'b1, 16'h0200, 8'd2, RESP_SLVERR, -1, RESP_OKAY,   -1, RESP_SLVERR, 16'h0200};
    vecs[5] = '{1'b0, 16'h0100, 8'd3, RESP_OKAY,    1, RESP_DECERR, -1, RESP_DECERR, 16'h0100};
    vecs[6] = '{1'b0, 16'h0100, 8'd3, RESP_OKAY,   -1, RESP_OKAY,    2, RESP_SLVERR, 16'h0100};
    vecs[7] = '{1'b0, 16'h0202, 8'd0, RESP_OKAY,   -1, RESP_OKAY,   -1, RESP_OKAY,   16'h0200};

    // Reset values while rst_n is low.
    #12;
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_bready_rready", {m_axi_bready, m_axi_rready}, 2'b00);
    chk("rst_sts", {sts_valid, sts_resp}, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      inj_bresp       = vecs[i].bresp;
      inj_rerr_beat   = vecs[i].rerr_beat;
      inj_rerr_val    = vecs[i].rerr_val;
      inj_rlast_early = vecs[i].rlast_early;
      if (vecs[i].wr) fill_wq(int'(vecs[i].len) + 1, i == 0, 1'b0);
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].len, 0, vecs[i].exp_resp,
              vecs[i].exp_aaddr, $sformatf("vec%0d", i));
      if (i == 0)
        for (int b = 0; b < 4; b++)
          chk($sformatf("ram_word_%0d", b), mem[16'h40 + b], 32'h11111111 * (b + 1));
    end
    inj_bresp = RESP_OKAY; inj_rerr_beat = -1; inj_rerr_val = RESP_OKAY; inj_rlast_early = -1;

    // Backpressure: toggling stream handshakes over 8-beat bursts.
    fill_wq(8, 1'b0, 1'b0);
    run_cmd(1'b1, 16'h0800, 8'd7, 1, RESP_OKAY, 16'h0800, "bp_wr");
    run_cmd(1'b0, 16'h0800, 8'd7, 1, RESP_OKAY, 16'h0800, "bp_rd");

    // Reset during the second W beat.
    fill_wq(4, 1'b0, 1'b0);
    accept_cmd(1'b1, 16'h0300, 8'd3, "rst_mid");
    wr_valid = 1'b1; wr_data = wq_data[0]; wr_strb = wq_strb[0];
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = wr_ready;
      @(posedge clk); #1;
    end
    chk("rst_mid_first_beat", hs, 1'b1);
    wr_data = wq_data[1]; wr_strb = wq_strb[1];
    #1;
    chk("rst_mid_wvalid_pre", m_axi_wvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wvalid", m_axi_wvalid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    wr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sts_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (sts_valid) sts_seen++;
    end
    chk("rst_mid_no_sts", sts_seen, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
    shadow.delete();
    @(posedge clk); #1;

    // Randomized commands against the shadow memory, with a stalling responder.
    rand_slave = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  len;
      wr   = 1'($urandom_range(0, 1));
      addr = 16'h0400 + 16'($urandom_range(0, 16'h0BFF));
      len  = 8'($urandom_range(0, 15));
      if (wr) fill_wq(int'(len) + 1, 1'b0, 1'b1);
      run_cmd(wr, addr, len, 2, RESP_OKAY, addr & 16'hFFFC, $sformatf("rnd%0d", i));
    end
    rand_slave = 1'b0;

    chk("addr_stable", stab_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
